// File: rtl/button_input_controller_pkg.sv
// Shared definitions for the push-button/switch input block:
// Avalon bus widths and register word offsets.
package button_input_controller_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] REG_STATE   = 8'd0;
   localparam logic [ADDR_W-1:0] REG_MASK    = 8'd1;
   localparam logic [ADDR_W-1:0] REG_EDGE    = 8'd2;
   localparam logic [ADDR_W-1:0] REG_EDGESEL = 8'd3;

endpackage

// File: rtl/button_input_controller_if.sv
// Avalon-MM slave port plus level IRQ of the button input block.
interface button_input_controller_if
   import button_input_controller_pkg::*;
();
   logic              WRITE;
   logic              READ;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] WDATA;
   logic [DATA_W-1:0] RDATA;
   logic              IRQ;

   modport master (output WRITE, READ, ADDR, WDATA, input  RDATA, IRQ);
   modport slave  (input  WRITE, READ, ADDR, WDATA, output RDATA, IRQ);
endinterface

// File: rtl/button_input_controller_debounce_bit.sv
// Single-pin debouncer: a new level is accepted only after it has differed
// from the current stable level for DEBOUNCE_CYCLES consecutive cycles.
module debounce_bit #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
)(
   input  logic CLK,
   input  logic RST,
   input  logic d_sync,
   output logic q_stable
);

   localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic          r_stable;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else if (d_sync == r_stable) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_stable <= d_sync;
         r_cnt    <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign q_stable = r_stable;

endmodule

// File: rtl/button_input_controller.sv
// Avalon-MM readable button/switch block: sync + debounce per pin, selectable
// edge capture with W1C clearing, maskable level IRQ, registered read data.
module button_input_controller
   import button_input_controller_pkg::*;
#(
   parameter int unsigned      WIDTH           = 8,
   parameter int unsigned      DEBOUNCE_CYCLES = 50000,
   parameter logic [WIDTH-1:0] INVERT          = '0
)(
   input  logic                     CLK,
   input  logic                     RST,
   button_input_controller_if.slave i_bus,
   input  logic [WIDTH-1:0]         BTN
);

   logic [WIDTH-1:0]  r_sync1, r_sync2, r_stable_d;
   logic [WIDTH-1:0]  r_mask, r_edge, r_edgesel;
   logic [WIDTH-1:0]  w_s, w_stable, w_rise, w_fall, w_evt;
   logic [WIDTH-1:0]  w_wdata, w_clr, w_edge_next, w_mask_next;
   logic              w_wr_mask, w_wr_edge, w_wr_edgesel;
   logic [DATA_W-1:0] w_rd;
   logic              w_unused_wdata;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= BTN;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = r_sync2 ^ INVERT;

   for (genvar g = 0; g < WIDTH; g++) begin : g_db
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .CLK      (CLK),
         .RST      (RST),
         .d_sync   (w_s[g]),
         .q_stable (w_stable[g])
      );
   end

   // stable_d resets to the same value as stable, so reset never looks like an edge
   assign w_rise = w_stable & ~r_stable_d;
   assign w_fall = ~w_stable & r_stable_d;
   assign w_evt  = (w_rise & r_edgesel) | (w_fall & ~r_edgesel);

   assign w_wdata        = i_bus.WDATA[WIDTH-1:0];
   assign w_unused_wdata = &{1'b0, i_bus.WDATA};
   assign w_wr_mask      = i_bus.WRITE && (i_bus.ADDR == REG_MASK);
   assign w_wr_edge      = i_bus.WRITE && (i_bus.ADDR == REG_EDGE);
   assign w_wr_edgesel   = i_bus.WRITE && (i_bus.ADDR == REG_EDGESEL);

   // a new event is OR-ed in after the clear, so a coincident edge is never lost
   assign w_clr       = w_wr_edge ? w_wdata : '0;
   assign w_edge_next = (r_edge & ~w_clr) | w_evt;
   assign w_mask_next = w_wr_mask ? w_wdata : r_mask;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_stable_d <= '0;
         r_mask     <= '0;
         r_edge     <= '0;
         r_edgesel  <= '1;
         i_bus.IRQ  <= 1'b0;
      end else begin
         r_stable_d <= w_stable;
         r_mask     <= w_mask_next;
         r_edge     <= w_edge_next;
         if (w_wr_edgesel) r_edgesel <= w_wdata;
         i_bus.IRQ  <= |(w_edge_next & w_mask_next);
      end
   end

   // NOTE: default assignment first so no path through the case leaves w_rd unassigned (no latch).
   always_comb begin
      w_rd = '0;
      case (i_bus.ADDR)
         REG_STATE:   w_rd[WIDTH-1:0] = w_stable;
         REG_MASK:    w_rd[WIDTH-1:0] = r_mask;
         REG_EDGE:    w_rd[WIDTH-1:0] = r_edge;
         REG_EDGESEL: w_rd[WIDTH-1:0] = r_edgesel;
         default:     ;
      endcase
   end

   // read mux uses pre-write register values, so read+write returns the old value
   always_ff @(posedge CLK) begin
      if (RST)             i_bus.RDATA <= '0;
      else if (i_bus.READ) i_bus.RDATA <= w_rd;
   end

endmodule

// File: tb/tb_button_input_controller.sv
// Self-checking bench for button_input_controller (WIDTH=4, DEBOUNCE_CYCLES=4)
// against a history-window reference model of debounce, edge capture and IRQ.
module tb_button_input_controller;

   localparam int         W   = 4;
   localparam int         D   = 4;
   localparam logic [3:0] INV = 4'b0000;

   logic       CLK = 1'b0;
   logic       RST;
   logic [3:0] BTN;
   int         checks = 0;
   int         errors = 0;

   button_input_controller_if bus ();

   button_input_controller #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .INVERT          (INV)
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .i_bus (bus),
      .BTN   (BTN)
   );

   always #5 CLK = ~CLK;

   // Reference model: a pin's level is accepted when the last D synchronised
   // samples all disagree with the current accepted level.
   logic [3:0]  m_pipe0, m_pipe1;
   logic [3:0]  m_hist [D];
   logic [3:0]  m_stable, m_stable_d, m_edg, m_mask, m_sel;
   logic [31:0] m_rdata;
   logic        m_irq;

   task automatic model_step();
      logic [3:0] s_now, nxt, evt, clr, edg_n, mask_n, sel_n;
      logic       all_diff;
      if (RST) begin
         m_pipe0 = '0; m_pipe1 = '0;
         for (int i = 0; i < D; i++) m_hist[i] = '0;
         m_stable = '0; m_stable_d = '0; m_edg = '0; m_mask = '0;
         m_sel = 4'hF; m_rdata = '0; m_irq = 1'b0;
         return;
      end
      s_now = m_pipe1;
      for (int i = 0; i < D - 1; i++) m_hist[i] = m_hist[i+1];
      m_hist[D-1] = s_now;
      nxt = m_stable;
      for (int b = 0; b < W; b++) begin
         all_diff = 1'b1;
         for (int i = 0; i < D; i++)
            if (m_hist[i][b] == m_stable[b]) all_diff = 1'b0;
         if (all_diff) nxt[b] = ~m_stable[b];
      end
      evt    = (m_sel & m_stable & ~m_stable_d) | (~m_sel & ~m_stable & m_stable_d);
      clr    = (bus.WRITE && bus.ADDR == 8'd2) ? bus.WDATA[3:0] : 4'h0;
      edg_n  = (m_edg & ~clr) | evt;
      mask_n = (bus.WRITE && bus.ADDR == 8'd1) ? bus.WDATA[3:0] : m_mask;
      sel_n  = (bus.WRITE && bus.ADDR == 8'd3) ? bus.WDATA[3:0] : m_sel;
      if (bus.READ) begin
         case (bus.ADDR)
            8'd0:    m_rdata = {28'd0, m_stable};
            8'd1:    m_rdata = {28'd0, m_mask};
            8'd2:    m_rdata = {28'd0, m_edg};
            8'd3:    m_rdata = {28'd0, m_sel};
            default: m_rdata = 32'd0;
         endcase
      end
      m_irq      = |(edg_n & mask_n);
      m_pipe1    = m_pipe0;
      m_pipe0    = BTN ^ INV;
      m_stable_d = m_stable;
      m_stable   = nxt;
      m_edg      = edg_n;
      m_mask     = mask_n;
      m_sel      = sel_n;
   endtask

   task automatic tick();
      model_step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      bus.WRITE = 1'b1; bus.ADDR = a; bus.WDATA = d;
      tick();
      bus.WRITE = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      bus.READ = 1'b1; bus.ADDR = a;
      tick();
      bus.READ = 1'b0;
      d = bus.RDATA;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [31:0] exp_rst [4];
      exp_rst[0] = 32'h0; exp_rst[1] = 32'h0; exp_rst[2] = 32'h0; exp_rst[3] = 32'hF;
      RST = 1'b1; BTN = '0;
      bus.WRITE = 1'b0; bus.READ = 1'b0; bus.ADDR = '0; bus.WDATA = '0;
      wait_cycles(3);
      RST = 1'b0;
      checks++;
      if (bus.RDATA !== 32'h0 || bus.IRQ !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: RDATA=%h IRQ=%b want 0/0", bus.RDATA, bus.IRQ);
      end
      for (int a = 0; a < 4; a++) begin
         rd(8'(a), d);
         checks++;
         if (d !== exp_rst[a] || d !== m_rdata) begin
            errors++;
            $display("FAIL reset_reg%0d: got %h want %h", a, d, exp_rst[a]);
         end
      end
      checks++;
      if (bus.IRQ !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq: got %b want 0", bus.IRQ);
      end
   endtask

   task automatic test_debounce_latency();
      logic [31:0] d;
      int first = -1;
      BTN = 4'b0001;
      for (int c = 1; c <= 12; c++) begin
         bus.READ = 1'b1; bus.ADDR = 8'd0;
         tick();
         checks++;
         if (bus.RDATA !== m_rdata) begin
            errors++;
            $display("FAIL latency_state c%0d: got %h want %h", c, bus.RDATA, m_rdata);
         end
         if (first < 0 && bus.RDATA[0] === 1'b1) first = c;
      end
      bus.READ = 1'b0;
      checks++;
      if (first != 7) begin
         errors++;
         $display("FAIL latency_first: state seen on read %0d want 7", first);
      end
      rd(8'd2, d);
      checks++;
      if (d !== 32'h1 || d !== m_rdata) begin
         errors++;
         $display("FAIL latency_edge: got %h want 00000001", d);
      end
      checks++;
      if (bus.IRQ !== 1'b0) begin
         errors++;
         $display("FAIL latency_irq: got %b want 0", bus.IRQ);
      end
   endtask

   task automatic test_glitch();
      logic [31:0] d;
      BTN = 4'b0011;
      wait_cycles(3);
      BTN = 4'b0001;
      wait_cycles(10);
      rd(8'd0, d);
      checks++;
      if (d !== 32'h1 || d !== m_rdata) begin
         errors++;
         $display("FAIL glitch_state: got %h want 00000001", d);
      end
      rd(8'd2, d);
      checks++;
      if (d !== 32'h1 || d !== m_rdata) begin
         errors++;
         $display("FAIL glitch_edge: got %h want 00000001", d);
      end
      BTN = 4'b0011;
      wait_cycles(10);
      rd(8'd0, d);
      checks++;
      if (d !== 32'h3 || d !== m_rdata) begin
         errors++;
         $display("FAIL held_state: got %h want 00000003", d);
      end
      rd(8'd2, d);
      checks++;
      if (d !== 32'h3 || d !== m_rdata) begin
         errors++;
         $display("FAIL held_edge: got %h want 00000003", d);
      end
   endtask

   task automatic test_irq();
      logic [31:0] d;
      bit seen = 1'b0;
      wr(8'd2, 32'hF);
      wr(8'd1, 32'h2);
      BTN = 4'b0001;
      wait_cycles(10);
      BTN = 4'b0011;
      for (int c = 0; c < 12; c++) begin
         tick();
         checks++;
         if (bus.IRQ !== m_irq) begin
            errors++;
            $display("FAIL irq_rise c%0d: got %b want %b", c, bus.IRQ, m_irq);
         end
         if (bus.IRQ === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL irq_seen: got 0 want 1 within budget");
      end
      wr(8'd2, 32'h2);
      checks++;
      if (bus.IRQ !== 1'b0) begin
         errors++;
         $display("FAIL irq_clear: got %b want 0", bus.IRQ);
      end
      BTN = 4'b0001;
      wait_cycles(10);
      BTN = 4'b0011;
      wait_cycles(6);
      wr(8'd2, 32'h2);
      checks++;
      if (bus.IRQ !== 1'b1 || m_irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_coincident: got %b want 1", bus.IRQ);
      end
      rd(8'd2, d);
      checks++;
      if (d[1] !== 1'b1 || d !== m_rdata) begin
         errors++;
         $display("FAIL coincident_edge: got %h want bit1 set (%h)", d, m_rdata);
      end
   endtask

   task automatic test_fall_select();
      logic [31:0] d;
      wr(8'd2, 32'hF);
      wr(8'd3, 32'h0);
      BTN = 4'b0010;
      wait_cycles(10);
      rd(8'd2, d);
      checks++;
      if (d !== 32'h1 || d !== m_rdata) begin
         errors++;
         $display("FAIL fall_capture: got %h want 00000001", d);
      end
      wr(8'd2, 32'hF);
      BTN = 4'b0011;
      wait_cycles(10);
      rd(8'd2, d);
      checks++;
      if (d !== 32'h0 || d !== m_rdata) begin
         errors++;
         $display("FAIL rise_ignored: got %h want 00000000", d);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      int first = -1;
      BTN = 4'b0111;
      wait_cycles(4);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      rd(8'd2, d);
      checks++;
      if (d !== 32'h0 || d !== m_rdata) begin
         errors++;
         $display("FAIL rstmid_edge: got %h want 00000000", d);
      end
      for (int c = 2; c <= 12; c++) begin
         bus.READ = 1'b1; bus.ADDR = 8'd0;
         tick();
         checks++;
         if (bus.RDATA !== m_rdata) begin
            errors++;
            $display("FAIL rstmid_state c%0d: got %h want %h", c, bus.RDATA, m_rdata);
         end
         if (first < 0 && bus.RDATA !== 32'h0) first = c;
      end
      bus.READ = 1'b0;
      checks++;
      if (first != 7) begin
         errors++;
         $display("FAIL rstmid_requal: state seen on read %0d want 7", first);
      end
   endtask

   task automatic test_random();
      int hold = 0;
      int op;
      for (int c = 0; c < 600; c++) begin
         if (hold == 0) begin
            BTN  = 4'($urandom);
            hold = $urandom_range(1, 10);
         end
         hold--;
         op        = $urandom_range(0, 9);
         bus.READ  = (op < 5);
         bus.WRITE = (op >= 7);
         bus.ADDR  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255))
                                                 : 8'($urandom_range(0, 3));
         bus.WDATA = $urandom;
         tick();
         checks++;
         if (bus.RDATA !== m_rdata || bus.IRQ !== m_irq) begin
            errors++;
            $display("FAIL random c%0d: RDATA=%h IRQ=%b want %h/%b",
                     c, bus.RDATA, bus.IRQ, m_rdata, m_irq);
         end
      end
      bus.READ = 1'b0; bus.WRITE = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_debounce_latency();
      test_glitch();
      test_irq();
      test_fall_select();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
